drive_cmd_motor_driver: RTL and testbench
=========================================

// Module: drive_cmd_motor_driver
// PURPOSE
//  Executes the 3-bit drive_cmd produced by the navigation logic on two L298N-style H-bridge channels (left, right).
//  - Decodes each command into per-wheel direction and duty.
//  - Generates edge-aligned PWM, soft-start duty ramp and break-before-make dead time on direction reversal.
//  - Sits between the wall-following decision stage and the motor pins.
// PARAMETERS
//  PWM_PERIOD   1000  PWM counter period in clk cycles (counter 0..PWM_PERIOD-1), 16-bit
//  DUTY_FWD     700   target duty (counts) for both wheels on CMD_FWD
//  DUTY_TURN    500   target duty (counts) for both wheels on CMD_LEFT/CMD_RIGHT
//  DEADTIME_CYC 5000  cycles a wheel is held off between opposite directions
//  RAMP_DIV     100   cycles between duty ramp steps
//  RAMP_STEP    10    duty increment per ramp step
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  drive_cmd    in   3   000 STOP, 001 FWD, 010 LEFT (pivot), 011 RIGHT (pivot); 1xx treated as STOP
//  motor_l_in1  out  1   left bridge IN1 (1 = forward leg)
//  motor_l_in2  out  1   left bridge IN2 (1 = reverse leg)
//  motor_l_en   out  1   left bridge enable / PWM
//  motor_r_in1  out  1   right bridge IN1
//  motor_r_in2  out  1   right bridge IN2
//  motor_r_en   out  1   right bridge enable / PWM
//  drive_busy   out  1   1 while either wheel is in DEADTIME or ramping below target
// BEHAVIOUR
//  - Reset: all outputs 0; PWM counter 0; both channels IDLE with duty 0.
//  - drive_cmd is registered once (cmd_q). All outputs are registered.
//    A direction change needing no dead time appears on inX 2 rising edges after drive_cmd changes.
//  - Decode (left, right):
//    - FWD  -> (FWD, FWD) at DUTY_FWD.
//    - LEFT -> (REV, FWD) at DUTY_TURN.
//    - RIGHT -> (FWD, REV) at DUTY_TURN.
//    - STOP/1xx -> (OFF, OFF), duty 0.
//  - Direction pins: FWD in1=1,in2=0; REV in1=0,in2=1; OFF/DEADTIME in1=0,in2=0. in1 and in2 are never both 1 (except active-brake mode).
//  - Per-wheel FSM:
//    - IDLE: target != OFF -> RUN with that direction, duty 0.
//    - RUN: target OFF -> IDLE next cycle, duty cleared immediately (no ramp-down).
//    - RUN: target opposite direction -> DEADTIME. Pins and en forced 0 that cycle; duty cleared; counter loaded with DEADTIME_CYC-1.
//    - RUN: target same direction -> stay in RUN; only the target duty changes.
//    - DEADTIME: counts to 0, then RUN in the latest target direction, or IDLE if the latest target is OFF.
//      - A target change during DEADTIME does not restart or abort the count.
//      - STOP during DEADTIME -> IDLE immediately.
//  - Ramp (RUN only):
//    - Every RAMP_DIV cycles, duty_cur += RAMP_STEP, saturating at target.
//    - If target < duty_cur, duty_cur = target at once.
//    - Ramp divider is free-running and shared by both wheels.
//  - PWM:
//    - Shared counter wraps PWM_PERIOD-1 -> 0.
//    - en = (cnt < duty_applied).
//    - duty_applied loads duty_cur only on wrap (glitch-free), except it is forced 0 immediately on IDLE/DEADTIME entry.
//    - Duty 0 -> en constantly 0; duty >= PWM_PERIOD -> en constantly 1.
//  - rst_n asserted mid-operation: all pins drop to 0 asynchronously; an in-progress dead time is not resumed.
//  - drive_busy = OR over wheels of (state==DEADTIME || (state==RUN && duty_cur<target)).
// CONFIGURATION
//  - MOTOR_ACTIVE_BRAKE_EN defined: in IDLE, in1=1, in2=1, en=1 (short brake).
//    DEADTIME still drives in1=in2=en=0.
//  - Not defined: IDLE coasts with in1=in2=en=0.
// STRUCTURE
//  - Package drive_pkg:
//    - CMD_STOP/CMD_FWD/CMD_LEFT/CMD_RIGHT localparams (shared with the navigation logic).
//    - Wheel direction encoding DIR_OFF/DIR_FWD/DIR_REV.
//    - Channel state encoding IDLE/RUN/DEADTIME.
//  - Sub-module motor_channel, instanced twice:
//    - Inputs: target dir, target duty, pwm_cnt, pwm_wrap, ramp_tick.
//    - Contents: FSM, dead-time counter, ramp, duty_applied, pin registers.
//  - Top contains: cmd register, decode, shared PWM counter, ramp divider, drive_busy.
// TESTING  (bench params: PWM_PERIOD=10, DUTY_FWD=8, DUTY_TURN=6, DEADTIME_CYC=4, RAMP_DIV=2, RAMP_STEP=2)
//  1. Reset, hold STOP 20 cycles -> all pins 0, drive_busy 0.
//  2. STOP->FWD -> both in1=1 after 2 edges; duty ramps 0,2,4,6,8 every 2 cycles; en high for exactly 8 of 10 counts once settled; busy clears at 8.
//  3. FWD steady, then LEFT -> left wheel in1=in2=en=0 for 4 cycles then in2=1 at duty ramping to 6; right stays in1=1, duty drops 8->6 at next wrap, no dead time.
//  4. LEFT during left-wheel dead time, then RIGHT at cycle 2 -> dead time still ends at cycle 4; wheel resumes FWD; never in1=in2=1.
//  5. drive_cmd=3'b111 while FWD -> both wheels IDLE; en=0 the cycle after cmd_q updates.
//     With MOTOR_ACTIVE_BRAKE_EN -> in1=in2=en=1.
//  6. rst_n low mid-dead-time for 1 cycle, cmd FWD held -> pins 0 async; after release, RUN FWD from duty 0 with no dead time.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared drive command codes, wheel direction and channel state encodings
// used by the motor driver and the navigation logic.
package drive_pkg;

  localparam logic [2:0] CMD_STOP  = 3'b000;
  localparam logic [2:0] CMD_FWD   = 3'b001;
  localparam logic [2:0] CMD_LEFT  = 3'b010;
  localparam logic [2:0] CMD_RIGHT = 3'b011;

  typedef enum logic [1:0] {
    DIR_OFF = 2'd0,
    DIR_FWD = 2'd1,
    DIR_REV = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DEADTIME = 2'd2
  } ch_state_t;

  typedef struct packed {
    dir_t        dir;
    logic [15:0] duty;
  } wheel_tgt_t;

endpackage

// File: rtl/motor_channel.sv
// One H-bridge channel: direction FSM, dead time, duty ramp and PWM pins.
// MOTOR_ACTIVE_BRAKE_EN selects short-brake instead of coast in IDLE.
module motor_channel
  import drive_pkg::*;
#(
  parameter int unsigned DEADTIME_CYC = 5000,
  parameter int unsigned RAMP_STEP    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  dir_t        tgt_dir,
  input  logic [15:0] tgt_duty,
  input  logic [15:0] pwm_cnt,
  input  logic        pwm_wrap,
  input  logic        ramp_tick,
  output logic        in1,
  output logic        in2,
  output logic        en,
  output logic        busy
);

  localparam logic [31:0] DT_LOAD = 32'(DEADTIME_CYC - 1);

  ch_state_t   state, state_n;
  dir_t        dir, dir_n;
  logic [15:0] duty_cur, duty_n;
  logic [15:0] duty_app, dap_n;
  logic [31:0] dt_cnt, dt_n;
  logic [16:0] ramp_sum;
  logic [15:0] ramp_duty;
  logic [15:0] cnt_nx;
  logic        run_n;
  logic        in1_d, in2_d, en_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dir      <= DIR_OFF;
      duty_cur <= '0;
      duty_app <= '0;
      dt_cnt   <= '0;
      in1      <= 1'b0;
      in2      <= 1'b0;
      en       <= 1'b0;
    end else begin
      state    <= state_n;
      dir      <= dir_n;
      duty_cur <= duty_n;
      duty_app <= dap_n;
      dt_cnt   <= dt_n;
      in1      <= in1_d;
      in2      <= in2_d;
      en       <= en_d;
    end
  end

  assign ramp_sum  = {1'b0, duty_cur} + 17'(RAMP_STEP);
  assign ramp_duty = (tgt_duty < duty_cur) ? tgt_duty :
                     !ramp_tick ? duty_cur :
                     (ramp_sum >= {1'b0, tgt_duty}) ? tgt_duty :
                     ramp_sum[15:0];

  always_comb begin
    state_n = state;
    dir_n   = dir;
    duty_n  = duty_cur;
    dt_n    = dt_cnt;
    unique case (state)
      IDLE: begin
        if (tgt_dir != DIR_OFF) begin
          state_n = RUN;
          dir_n   = tgt_dir;
          duty_n  = '0;
        end
      end
      RUN: begin
        if (tgt_dir == DIR_OFF) begin
          state_n = IDLE;
          dir_n   = DIR_OFF;
          duty_n  = '0;
        end else if (tgt_dir != dir) begin
          state_n = DEADTIME;
          dir_n   = DIR_OFF;
          duty_n  = '0;
          dt_n    = DT_LOAD;
        end else begin
          duty_n  = ramp_duty;
        end
      end
      DEADTIME: begin
        // target changes here never restart the count
        if (tgt_dir == DIR_OFF) begin
          state_n = IDLE;
        end else if (dt_cnt == '0) begin
          state_n = RUN;
          dir_n   = tgt_dir;
        end else begin
          dt_n    = dt_cnt - 32'd1;
        end
      end
      default: begin
        state_n = IDLE;
        dir_n   = DIR_OFF;
        duty_n  = '0;
      end
    endcase
  end

  // pins are registered from the next state so they track it edge-exact
  always_comb begin
    run_n  = (state_n == RUN);
    cnt_nx = pwm_wrap ? 16'd0 : pwm_cnt + 16'd1;
    if (!run_n)
      dap_n = '0;
    else if (pwm_wrap)
      dap_n = duty_cur;
    else
      dap_n = duty_app;
    in1_d = run_n && (dir_n == DIR_FWD);
    in2_d = run_n && (dir_n == DIR_REV);
    en_d  = run_n && (cnt_nx < dap_n);
`ifdef MOTOR_ACTIVE_BRAKE_EN
    if (state_n == IDLE) begin
      in1_d = 1'b1;
      in2_d = 1'b1;
      en_d  = 1'b1;
    end
`endif
  end

  assign busy = (state == DEADTIME) ||
                ((state == RUN) && (duty_cur < tgt_duty));

endmodule

// File: rtl/drive_cmd_motor_driver.sv
// Drive command decoder and shared PWM/ramp timebase for two H-bridges.
// MOTOR_ACTIVE_BRAKE_EN (in motor_channel) brakes instead of coasting.
module drive_cmd_motor_driver
  import drive_pkg::*;
#(
  parameter int unsigned PWM_PERIOD   = 1000,
  parameter int unsigned DUTY_FWD     = 700,
  parameter int unsigned DUTY_TURN    = 500,
  parameter int unsigned DEADTIME_CYC = 5000,
  parameter int unsigned RAMP_DIV     = 100,
  parameter int unsigned RAMP_STEP    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] drive_cmd,
  output logic       motor_l_in1,
  output logic       motor_l_in2,
  output logic       motor_l_en,
  output logic       motor_r_in1,
  output logic       motor_r_in2,
  output logic       motor_r_en,
  output logic       drive_busy
);

  logic [2:0]  cmd_q;
  logic [15:0] pwm_cnt;
  logic        pwm_wrap;
  logic [15:0] ramp_div;
  logic        ramp_tick;
  wheel_tgt_t  tgt_l, tgt_r;
  logic        busy_l, busy_r;

  assign pwm_wrap  = (pwm_cnt == 16'(PWM_PERIOD - 1));
  assign ramp_tick = (ramp_div == 16'(RAMP_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= CMD_STOP;
      pwm_cnt  <= '0;
      ramp_div <= '0;
    end else begin
      cmd_q    <= drive_cmd;
      pwm_cnt  <= pwm_wrap ? 16'd0 : pwm_cnt + 16'd1;
      ramp_div <= ramp_tick ? 16'd0 : ramp_div + 16'd1;
    end
  end

  always_comb begin
    tgt_l = '{DIR_OFF, 16'd0};
    tgt_r = '{DIR_OFF, 16'd0};
    unique case (1'b1)
      (cmd_q == CMD_FWD): begin
        tgt_l = '{DIR_FWD, 16'(DUTY_FWD)};
        tgt_r = '{DIR_FWD, 16'(DUTY_FWD)};
      end
      (cmd_q == CMD_LEFT): begin
        tgt_l = '{DIR_REV, 16'(DUTY_TURN)};
        tgt_r = '{DIR_FWD, 16'(DUTY_TURN)};
      end
      (cmd_q == CMD_RIGHT): begin
        tgt_l = '{DIR_FWD, 16'(DUTY_TURN)};
        tgt_r = '{DIR_REV, 16'(DUTY_TURN)};
      end
      default: begin
        tgt_l = '{DIR_OFF, 16'd0};
        tgt_r = '{DIR_OFF, 16'd0};
      end
    endcase
  end

  motor_channel #(
    .DEADTIME_CYC(DEADTIME_CYC),
    .RAMP_STEP   (RAMP_STEP)
  ) u_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .tgt_dir  (tgt_l.dir),
    .tgt_duty (tgt_l.duty),
    .pwm_cnt  (pwm_cnt),
    .pwm_wrap (pwm_wrap),
    .ramp_tick(ramp_tick),
    .in1      (motor_l_in1),
    .in2      (motor_l_in2),
    .en       (motor_l_en),
    .busy     (busy_l)
  );

  motor_channel #(
    .DEADTIME_CYC(DEADTIME_CYC),
    .RAMP_STEP   (RAMP_STEP)
  ) u_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .tgt_dir  (tgt_r.dir),
    .tgt_duty (tgt_r.duty),
    .pwm_cnt  (pwm_cnt),
    .pwm_wrap (pwm_wrap),
    .ramp_tick(ramp_tick),
    .in1      (motor_r_in1),
    .in2      (motor_r_in2),
    .en       (motor_r_en),
    .busy     (busy_r)
  );

  assign drive_busy = busy_l | busy_r;

endmodule

// File: tb/tb_drive_cmd_motor_driver.sv
// Directed bench for drive_cmd_motor_driver with small timing parameters.
// Pin triples below are {in1,in2,en}; edge numbers count from reset release.
module tb_drive_cmd_motor_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] drive_cmd;
  logic       motor_l_in1, motor_l_in2, motor_l_en;
  logic       motor_r_in1, motor_r_in2, motor_r_en;
  logic       drive_busy;
  logic [2:0] pl, pr;

  int ec = 0;
  int base = 0;
  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int hl, hr;

`ifdef MOTOR_ACTIVE_BRAKE_EN
  localparam logic [7:0] IDLE_PINS = 8'b111;
`else
  localparam logic [7:0] IDLE_PINS = 8'b000;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  assign pl = {motor_l_in1, motor_l_in2, motor_l_en};
  assign pr = {motor_r_in1, motor_r_in2, motor_r_en};

  drive_cmd_motor_driver #(
    .PWM_PERIOD  (10),
    .DUTY_FWD    (8),
    .DUTY_TURN   (6),
    .DEADTIME_CYC(4),
    .RAMP_DIV    (2),
    .RAMP_STEP   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .drive_cmd  (drive_cmd),
    .motor_l_in1(motor_l_in1),
    .motor_l_in2(motor_l_in2),
    .motor_l_en (motor_l_en),
    .motor_r_in1(motor_r_in1),
    .motor_r_in2(motor_r_in2),
    .motor_r_en (motor_r_en),
    .drive_busy (drive_busy)
  );

`ifndef MOTOR_ACTIVE_BRAKE_EN
  always @(negedge clk) begin
    if ((motor_l_in1 & motor_l_in2) | (motor_r_in1 & motor_r_in2))
      overlap <= overlap + 1;
  end
`endif

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic at(input int n);
    while (ec - base < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_cmd = 3'b000;
    #3;
    chk("rst_l", 8'(pl), 8'b000);
    chk("rst_r", 8'(pr), 8'b000);
    chk("rst_busy", 8'(drive_busy), 8'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = ec;

    at(20);
    chk("stop_l", 8'(pl), IDLE_PINS);
    chk("stop_r", 8'(pr), IDLE_PINS);
    chk("stop_busy", 8'(drive_busy), 8'd0);
    drive_cmd = 3'b001;
    at(21);
    chk("fwd_edge1_l", 8'(pl), IDLE_PINS);
    at(22);
    chk("fwd_edge2_l", 8'(pl), 8'b100);
    chk("fwd_edge2_r", 8'(pr), 8'b100);
    chk("fwd_busy", 8'(drive_busy), 8'd1);
    at(29);
    chk("ramp_busy6", 8'(drive_busy), 8'd1);
    at(30);
    chk("ramp_busy8", 8'(drive_busy), 8'd0);
    at(35);
    chk("duty6_cnt5", 8'(pl), 8'b101);
    at(36);
    chk("duty6_cnt6", 8'(pl), 8'b100);
    hl = 0;
    hr = 0;
    for (int k = 40; k < 50; k++) begin
      at(k);
      hl += int'(motor_l_en);
      hr += int'(motor_r_en);
    end
    chk("duty8_l", 8'(hl), 8'd8);
    chk("duty8_r", 8'(hr), 8'd8);

    at(50);
    drive_cmd = 3'b010;
    at(51);
    chk("left_e1_l", 8'(pl), 8'b101);
    at(52);
    chk("left_dt0_l", 8'(pl), 8'b000);
    chk("left_dt0_r", 8'(pr), 8'b101);
    chk("left_dt_busy", 8'(drive_busy), 8'd1);
    at(55);
    chk("left_dt3_l", 8'(pl), 8'b000);
    at(56);
    chk("left_rev_l", 8'(pl), 8'b010);
    at(57);
    chk("right_old8_c7", 8'(pr), 8'b101);
    at(58);
    chk("right_old8_c8", 8'(pr), 8'b100);
    at(61);
    chk("left_duty2_c1", 8'(pl), 8'b011);
    chk("left_ramp_busy", 8'(drive_busy), 8'd1);
    at(62);
    chk("left_duty2_c2", 8'(pl), 8'b010);
    chk("left_ramp_done", 8'(drive_busy), 8'd0);
    at(65);
    chk("right_new6_c5", 8'(pr), 8'b101);
    at(66);
    chk("right_new6_c6", 8'(pr), 8'b100);

    at(70);
    drive_cmd = 3'b001;
    at(100);
    drive_cmd = 3'b010;
    at(103);
    chk("dt_hold_l", 8'(pl), 8'b000);
    drive_cmd = 3'b011;
    at(104);
    chk("dt_hold_r", 8'(pr), 8'b101);
    at(105);
    chk("dt_end_wait_l", 8'(pl), 8'b000);
    chk("dt_start_r", 8'(pr), 8'b000);
    at(106);
    chk("dt_end_fwd_l", 8'(pl), 8'b100);
    at(108);
    chk("dt_r_last", 8'(pr), 8'b000);
    at(109);
    chk("dt_r_rev", 8'(pr), 8'b010);

    at(120);
    drive_cmd = 3'b001;
    at(150);
    chk("fwd2_l", 8'(pl), 8'b101);
    chk("fwd2_r", 8'(pr), 8'b101);
    chk("fwd2_busy", 8'(drive_busy), 8'd0);
    drive_cmd = 3'b111;
    at(151);
    chk("c111_e1_l", 8'(pl), 8'b101);
    at(152);
    chk("c111_idle_l", 8'(pl), IDLE_PINS);
    chk("c111_idle_r", 8'(pr), IDLE_PINS);
    chk("c111_busy", 8'(drive_busy), 8'd0);

    at(160);
    drive_cmd = 3'b010;
    at(170);
    drive_cmd = 3'b001;
    at(173);
    chk("pre_rst_dt_l", 8'(pl), 8'b000);
    chk("pre_rst_r_in1", 8'(motor_r_in1), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_l", 8'(pl), 8'b000);
    chk("async_rst_r", 8'(pr), 8'b000);
    chk("async_rst_busy", 8'(drive_busy), 8'd0);
    at(174);
    rst_n = 1'b1;
    at(175);
    chk("post_rst_e1_l", 8'(pl), IDLE_PINS);
    at(176);
    chk("post_rst_run_l", 8'(pl), 8'b100);
    chk("post_rst_run_r", 8'(pr), 8'b100);
    chk("post_rst_busy", 8'(drive_busy), 8'd1);
    at(183);
    chk("post_rst_ramp6", 8'(drive_busy), 8'd1);
    at(184);
    chk("post_rst_ramp8", 8'(drive_busy), 8'd0);

    chk("no_shoot_through", 8'(overlap), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
